// File: rtl/tt10_pkg.sv
// Shared types and constants for the S - A subtractor with output FIFO.
// Optional build macro: TT10_SATURATE_EN (clamp D to 0 on borrow).
package tt10_pkg;

    localparam int unsigned DataWidth  = 8;
    localparam int unsigned FifoDepth  = 4;
    localparam int unsigned EntryWidth = DataWidth + 1;

    // Two-state input sequencer: first beat is S, second beat is A.
    typedef logic [0:0] state_t;
    localparam state_t LOAD_S = 1'b0;
    localparam state_t LOAD_A = 1'b1;

    // uio_in bit positions
    localparam int unsigned UioInValid  = 0;
    localparam int unsigned UioOutReady = 1;

    // uio_out bit positions
    localparam int unsigned UioInReady  = 7;
    localparam int unsigned UioOutValid = 6;
    localparam int unsigned UioBorrow   = 5;
    localparam int unsigned UioCountHi  = 4;
    localparam int unsigned UioCountLo  = 2;

    localparam logic [7:0] UioOeValue = 8'b1111_1100;

    // Packs {borrow, D} for one S/A pair; saturation zeroes D on borrow.
    function automatic logic [EntryWidth-1:0] sub_entry(input logic [DataWidth-1:0] s,
                                                        input logic [DataWidth-1:0] a,
                                                        input logic             sat);
        logic                 borrow;
        logic [DataWidth-1:0] diff;
        borrow = (a > s);
        diff   = s - a;
        if (sat && borrow) begin
            diff = '0;
        end
        return {borrow, diff};
    endfunction

endpackage

// File: rtl/tt10_fifo.sv
// Small synchronous FIFO with occupancy count; head reads as 0 when empty.
module tt10_fifo
    import tt10_pkg::*;
#(
    parameter int unsigned Width = EntryWidth,
    parameter int unsigned Depth = FifoDepth,
    parameter int unsigned PtrW  = $clog2(Depth),
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap at Depth-1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; stale contents are masked by the empty check on head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tt_um_tt10_sub_seq.sv
// Sequential subtractor: takes S then A over a valid/ready beat interface and
// queues {borrow, S - A} into a 4-entry FIFO drained by out_ready.
// Optional build macro: TT10_SATURATE_EN (D stored as 0 when borrow is set).
module tt_um_tt10_sub_seq
    import tt10_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   s_q, s_d;
    logic                   in_valid, out_ready, in_ready, out_valid;
    logic                   in_xfer, push;
    logic [EntryWidth-1:0]  entry, head;
    logic [CntW-1:0]        count;
    logic                   fifo_full, fifo_empty;
    logic                   sat;
    logic                   unused;

    assign in_valid  = uio_in[UioInValid];
    assign out_ready = uio_in[UioOutReady];
    assign unused    = &{1'b0, ena, uio_in[7:2]};

`ifdef TT10_SATURATE_EN
    assign sat = 1'b1;
`else
    assign sat = 1'b0;
`endif

    // Ready comes from registered state and FIFO count only, so a pop in the
    // same cycle cannot open the door for a push into a full FIFO.
    assign in_ready  = (state_q == LOAD_S) ? 1'b1 : !fifo_full;
    assign in_xfer   = in_valid && in_ready;
    assign push      = in_xfer && (state_q == LOAD_A);
    assign entry     = sub_entry(s_q, ui_in, sat);
    assign out_valid = !fifo_empty;

    // Beat sequencing: capture S, then push the result when A arrives.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        if (in_xfer) begin
            if (state_q == LOAD_S) begin
                s_d     = ui_in;
                state_d = LOAD_A;
            end else begin
                state_d = LOAD_S;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_S;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    tt10_fifo #(
        .Width (EntryWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (entry),
        .pop       (out_ready),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output packing; head is already zero when the FIFO is empty.
    always_comb begin
        uo_out                           = head[DataWidth-1:0];
        uio_out                          = '0;
        uio_out[UioInReady]              = in_ready;
        uio_out[UioOutValid]             = out_valid;
        uio_out[UioBorrow]               = head[DataWidth];
        uio_out[UioCountHi:UioCountLo]   = count;
        uio_oe                           = UioOeValue;
    end

endmodule

// File: tb/tb_tt_um_tt10_sub_seq.sv
// Directed, table-driven bench for tt_um_tt10_sub_seq. Inputs change and
// outputs are sampled on the falling edge; transfers happen on the rising edge.
module tb_tt_um_tt10_sub_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tt_um_tt10_sub_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] a;
        logic [7:0] d;
        logic       b;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Head, borrow, valid, count plus the constant bits.
    task automatic chk_out(input string name, input logic [7:0] d, input logic b,
                           input int cnt);
        chk({name, ".d"}, uo_out, d);
        chk({name, ".borrow"}, uio_out[5], b);
        chk({name, ".valid"}, uio_out[6], cnt != 0);
        chk({name, ".count"}, uio_out[4:2], cnt);
        chk({name, ".oe"}, uio_oe, 8'hFC);
        chk({name, ".lo"}, uio_out[1:0], 2'b00);
    endtask

    // Present one beat and hold it until accepted, with a cycle budget.
    task automatic send_beat(input string name, input logic [7:0] d);
        int waited = 0;
        ui_in = d;
        uio_in[0] = 1'b1;
        while (!uio_out[7] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!uio_out[7]) chk({name, ".accept_timeout"}, 0, 1);
        @(negedge clk);
        uio_in[0] = 1'b0;
    endtask

    task automatic send_pair(input string name, input logic [7:0] s, input logic [7:0] a);
        send_beat({name, ".S"}, s);
        send_beat({name, ".A"}, a);
    endtask

    task automatic pop_one(input string name, input logic [7:0] d, input logic b);
        chk({name, ".head"}, uo_out, d);
        chk({name, ".hborrow"}, uio_out[5], b);
        uio_in[1] = 1'b1;
        @(negedge clk);
        uio_in[1] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{s: 8'h50, a: 8'h20, d: 8'h30, b: 1'b0};
        vecs[1] = '{s: 8'h10, a: 8'h20, d: 8'hF0, b: 1'b1};
        vecs[2] = '{s: 8'hFF, a: 8'h01, d: 8'hFE, b: 1'b0};
        vecs[3] = '{s: 8'h00, a: 8'hFF, d: 8'h01, b: 1'b1};
        vecs[4] = '{s: 8'h7F, a: 8'h7F, d: 8'h00, b: 1'b0};
        vecs[5] = '{s: 8'h80, a: 8'h7F, d: 8'h01, b: 1'b0};
`ifdef TT10_SATURATE_EN
        foreach (vecs[i]) if (vecs[i].b) vecs[i].d = 8'h00;
`endif

        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 8'h00, 1'b0, 0);
        chk("reset.in_ready", uio_out[7], 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic case with out_ready held high: visible next cycle, popped next edge.
        uio_in[1] = 1'b1;
        send_pair("basic", 8'h50, 8'h20);
        chk_out("basic", 8'h30, 1'b0, 1);
        @(negedge clk);
        chk_out("basic.popped", 8'h00, 1'b0, 0);
        uio_in[1] = 1'b0;

        // Table: one pair at a time, check head, then pop.
        for (int i = 0; i < 6; i++) begin
            send_pair($sformatf("vec%0d", i), vecs[i].s, vecs[i].a);
            chk_out($sformatf("vec%0d", i), vecs[i].d, vecs[i].b, 1);
            pop_one($sformatf("vec%0d.pop", i), vecs[i].d, vecs[i].b);
            chk($sformatf("vec%0d.empty", i), uio_out[4:2], 0);
        end

        // Fill to 4, fifth pair blocked on A until one pop.
        for (int n = 1; n <= 4; n++) send_pair($sformatf("fill%0d", n), 8'(n), 8'h00);
        chk_out("full", 8'h01, 1'b0, 4);
        send_beat("fill5.S", 8'h05);
        chk("full.in_ready_A", uio_out[7], 1'b0);
        ui_in = 8'h00;
        uio_in[0] = 1'b1;
        @(negedge clk);
        chk("full.held_count", uio_out[4:2], 4);
        uio_in[1] = 1'b1;  // pop while A is still offered
        @(negedge clk);
        uio_in[1] = 1'b0;
        chk("full.after_pop_count", uio_out[4:2], 3);
        chk("full.after_pop_ready", uio_out[7], 1'b1);
        @(negedge clk);
        uio_in[0] = 1'b0;
        chk("full.fifth_pushed", uio_out[4:2], 4);
        for (int n = 2; n <= 5; n++) pop_one($sformatf("drain%0d", n), 8'(n), 1'b0);
        chk_out("drained", 8'h00, 1'b0, 0);

        // Simultaneous push and pop at count 2.
        send_pair("pp1", 8'h40, 8'h01);
        send_pair("pp2", 8'h41, 8'h01);
        send_beat("pp3.S", 8'h60);
        chk_out("pp.before", 8'h3F, 1'b0, 2);
        ui_in = 8'h10;
        uio_in[0] = 1'b1;
        uio_in[1] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        uio_in[1] = 1'b0;
        chk_out("pp.after", 8'h40, 1'b0, 2);
        pop_one("pp.drain1", 8'h40, 1'b0);
        pop_one("pp.drain2", 8'h50, 1'b0);
        chk("pp.empty", uio_out[4:2], 0);

        // Reset mid-operation discards S and FIFO contents.
        for (int n = 0; n < 3; n++) send_pair($sformatf("rq%0d", n), 8'h20, 8'(n));
        send_beat("rq.S", 8'hAA);
        chk("rq.count", uio_out[4:2], 3);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 8'h00, 1'b0, 0);
        chk("rst_mid.in_ready", uio_out[7], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pair("post_rst", 8'h05, 8'h03);
        chk_out("post_rst", 8'h02, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tt_um_tt10_sub_seq.md
TT_UM_TT10_SUB_SEQ -- requirements
Module: tt_um_tt10_sub_seq

Interface
REQ-001 The block SHALL use one clock, clk, with an asynchronous, active-low reset, rst_n.
REQ-002 Ports SHALL be as follows:
  clk  input  1  clock.
  rst_n  input  1  async active-low reset.
  ena  input  1  design powered (always 1), functionally ignored.
  ui_in  input  8  data beat (sum S on first beat, operand A on second).
  uo_out  output  8  difference D at FIFO head, 0 when empty.
  uio_in  input  8  bit0 in_valid, bit1 out_ready, bits7:2 ignored.
  uio_out  output  8  bit7 in_ready, bit6 out_valid, bit5 head borrow, bits4:2 FIFO count, bits1:0 = 0.
  uio_oe  output  8  constant 8'b1111_1100.
REQ-003 All unused inputs (ena, uio_in[7:2]) SHALL be consumed without affecting behaviour.

Function
REQ-004 Operation is the inverse of the team's combinational adder: receive S then A, produce D = S - A (mod 256) plus borrow = (A > S).
REQ-005 FSM states SHALL be LOAD_S and LOAD_A.
REQ-006 Input handshake: a beat transfers on a rising clk edge with in_valid=1 and in_ready=1.
REQ-007 In LOAD_S: in_ready=1; a transfer captures ui_in into S and moves to LOAD_A.
REQ-008 In LOAD_A: in_ready = !fifo_full; a transfer pushes {borrow, D} computed from S and ui_in into the FIFO on that same edge and returns to LOAD_S.
REQ-009 in_ready SHALL depend on registered state only, never combinationally on out_ready.
REQ-010 Output FIFO SHALL be 4 entries of 9 bits {borrow, D}; count 0..4 on uio_out[4:2].
REQ-011 out_valid = (count != 0); uo_out and uio_out[5] SHALL show the head entry, 0 when empty.
REQ-012 Pop occurs on an edge with out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-014 At count=4, a push is impossible (in_ready=0 in LOAD_A) even if a pop occurs that cycle; in_ready rises on the cycle after the pop.
REQ-015 Latency: result visible on uo_out the cycle after the A transfer when the FIFO was empty.
REQ-016 Read/write pointers SHALL be 2 bits and wrap from 3 to 0.

Reset
REQ-017 On rst_n=0, asynchronously: state=LOAD_S, S=0, pointers=0, count=0, uo_out=0, out_valid=0, borrow=0; in_ready=1 (after reset).
REQ-018 Reset mid-operation (S loaded, A pending) SHALL discard S and all FIFO contents.

Configuration
REQ-019 Macro TT10_SATURATE_EN defined: when borrow=1, stored D SHALL be 8'h00 (borrow bit still 1).
REQ-020 Macro TT10_SATURATE_EN undefined: D SHALL wrap modulo 256.

Structure
REQ-021 A shared package tt10_pkg SHALL hold the FSM state typedef, FIFO depth (4), data width (8), and the uio bit-index constants.
REQ-022 The FIFO SHALL be a separate sub-module, tt10_fifo (parameterised width/depth, count output); the top holds the FSM and subtractor.

Verification
REQ-023 S=8'h50, A=8'h20, out_ready=1 -> next cycle uo_out=8'h30, borrow=0, out_valid=1; popped next edge, count=0.
REQ-024 S=8'h10, A=8'h20 -> uo_out=8'hF0, borrow=1; with TT10_SATURATE_EN uo_out=8'h00, borrow=1.
REQ-025 out_ready=0, five S/A pairs (S=8'h0n, A=8'h00, n=1..5) -> count=4, in_ready=0 in LOAD_A after the 4th; one pop -> fifth pair accepted; drain order 01,02,03,04,05.
REQ-026 count=2, push and pop on the same edge -> count stays 2, popped value equals the old head.
REQ-027 rst_n pulsed low after S=8'hAA is loaded with 3 entries queued -> count=0, uo_out=0, in_ready=1; next pair S=8'h05, A=8'h03 yields 8'h02.
REQ-028 uio_oe SHALL read 8'hFC and uio_out[1:0]=0 in every test.
